adf_spi_receiver: RTL and testbench

- Receive end of the 3-wire ADF-style PLL programming bus (serial clock, serial data, latch enable).
- Deserialises MSB-first 32-bit words and decodes control bits [2:0] as the register address.
- Stores accepted words in a 6-entry shadow register file and decodes the R0 INT/FRAC fields back into a frequency code.
- Used as a bus monitor/slave model next to the PLL driver, and as the self-check block in that driver's bench.

---
 rtl/adf_pkg.sv | 24 ++
 rtl/adf_sync_edge.sv | 32 +++
 rtl/adf_spi_receiver.sv | 147 ++++++++++++++
 tb/tb_adf_spi_receiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adf_pkg.sv
// Shared constants for the ADF-style 3-wire PLL programming bus receiver:
// register addresses, R0 field positions and the receive FSM encoding.
package adf_pkg;

    localparam logic [2:0] ADDR_R0 = 3'd0;
    localparam logic [2:0] ADDR_R1 = 3'd1;
    localparam logic [2:0] ADDR_R2 = 3'd2;
    localparam logic [2:0] ADDR_R3 = 3'd3;
    localparam logic [2:0] ADDR_R4 = 3'd4;
    localparam logic [2:0] ADDR_R5 = 3'd5;

    localparam int CTRL_W   = 3;
    localparam int INT_MSB  = 30;
    localparam int INT_LSB  = 15;
    localparam int FRAC_MSB = 14;
    localparam int FRAC_LSB = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } adf_state_e;

endpackage

// File: rtl/adf_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with a one-flop edge
// detector behind it producing single-cycle rise/fall strobes.
module adf_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/adf_spi_receiver.sv
// Receive side of the ADF 3-wire PLL bus: deserialises latched 32-bit words,
// keeps a shadow register file and rebuilds the R0 frequency code.
module adf_spi_receiver
    import adf_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_BITS    = 32,
    parameter int MOD         = 100,
    parameter int NREGS       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sdata,
    input  logic        le,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        frame_valid,
    output logic [2:0]  frame_addr,
    output logic [31:0] frame_word,
    output logic        err_short,
    output logic        err_addr,
    output logic [15:0] r0_int,
    output logic [11:0] r0_frac,
    output logic [22:0] freq_code,
    output logic        freq_valid,
    output logic [15:0] frame_count
);

    localparam logic [5:0] MIN_BITS_C = 6'(MIN_BITS);
    localparam logic [3:0] NREGS_C    = 4'(NREGS);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_sdata_s, w_sdata_rise, w_sdata_fall;
    logic w_le_s, w_le_rise, w_le_fall;
    logic w_unused;

    adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_q(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk(clk), .rst_n(rst_n), .i_d(sdata),
        .o_q(w_sdata_s), .o_rise(w_sdata_rise), .o_fall(w_sdata_fall)
    );

    // le idles high, so its synchroniser resets high: no false frame start.
    adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
        .clk(clk), .rst_n(rst_n), .i_d(le),
        .o_q(w_le_s), .o_rise(w_le_rise), .o_fall(w_le_fall)
    );

    assign w_unused = &{1'b0, w_sclk_s, w_sclk_fall, w_sdata_rise, w_sdata_fall};

    adf_state_e  r_state, w_state_next;
    logic [31:0] r_shift;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_regfile [NREGS];
    logic [31:0] r_rd_data;
    logic [2:0]  r_frame_addr;
    logic [31:0] r_frame_word;
    logic [15:0] r_frame_count;
    logic [15:0] r_r0_int;
    logic [11:0] r_r0_frac;
    logic        r_r0_load;
    logic [22:0] r_freq_code;
    logic        r_freq_valid;

    logic w_latch, w_short, w_bad_addr, w_accept;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_le_fall) w_state_next = S_SHIFT;
            S_SHIFT: if (w_le_rise) w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_latch    = (r_state == S_LATCH);
    assign w_short    = (r_bit_cnt < MIN_BITS_C);
    assign w_bad_addr = ({1'b0, r_shift[CTRL_W-1:0]} >= NREGS_C);
    assign w_accept   = w_latch & ~w_short & ~w_bad_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_rd_data     <= '0;
            r_frame_addr  <= '0;
            r_frame_word  <= '0;
            r_frame_count <= '0;
            r_r0_int      <= '0;
            r_r0_frac     <= '0;
            r_r0_load     <= 1'b0;
            r_freq_code   <= '0;
            r_freq_valid  <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regfile[i] <= '0;
        end else begin
            r_state <= w_state_next;

            // A clock edge coinciding with the latch edge is not part of the word.
            if (r_state == S_IDLE && w_le_fall) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT && w_sclk_rise && !w_le_rise) begin
                r_shift <= {r_shift[30:0], w_sdata_s};
                if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if (w_accept) begin
                r_regfile[r_shift[CTRL_W-1:0]] <= r_shift;
                r_frame_word <= r_shift;
                r_frame_addr <= r_shift[CTRL_W-1:0];
                if (r_frame_count != 16'hFFFF) r_frame_count <= r_frame_count + 16'd1;
                if (r_shift[CTRL_W-1:0] == ADDR_R0) begin
                    r_r0_int  <= r_shift[INT_MSB:INT_LSB];
                    r_r0_frac <= r_shift[FRAC_MSB:FRAC_LSB];
                end
            end
            r_r0_load <= w_accept && (r_shift[CTRL_W-1:0] == ADDR_R0);

            r_freq_valid <= r_r0_load;
            if (r_r0_load) r_freq_code <= 23'(r_r0_int) * 23'(MOD) + 23'(r_r0_frac);

            if ({1'b0, rd_addr} < NREGS_C) r_rd_data <= r_regfile[rd_addr];
            else                           r_rd_data <= '0;
        end
    end

    assign rd_data     = r_rd_data;
    assign busy        = ~w_le_s;
    assign frame_valid = w_accept;
    assign err_short   = w_latch & w_short;
    assign err_addr    = w_latch & ~w_short & w_bad_addr;
    assign frame_addr  = r_frame_addr;
    assign frame_word  = r_frame_word;
    assign frame_count = r_frame_count;
    assign r0_int      = r_r0_int;
    assign r0_frac     = r_r0_frac;
    assign freq_code   = r_freq_code;
    assign freq_valid  = r_freq_valid;

endmodule

// File: tb/tb_adf_spi_receiver.sv
// Randomised bench for adf_spi_receiver: drives 3-wire frames and checks
// every outcome against a word-level model of the shadow register file.
module tb_adf_spi_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        sdata = 1'b0;
    logic        le = 1'b1;
    logic [2:0]  rd_addr = 3'd0;
    logic [31:0] rd_data;
    logic        busy, frame_valid, err_short, err_addr, freq_valid;
    logic [2:0]  frame_addr;
    logic [31:0] frame_word;
    logic [15:0] r0_int, frame_count;
    logic [11:0] r0_frac;
    logic [22:0] freq_code;

    adf_spi_receiver dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdata(sdata), .le(le),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_word(frame_word),
        .err_short(err_short), .err_addr(err_addr), .r0_int(r0_int), .r0_frac(r0_frac),
        .freq_code(freq_code), .freq_valid(freq_valid), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [8];
    int          m_count;
    int          frame_no = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_count = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd_data"}, rd_data, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_pulses"}, {28'd0, frame_valid, err_short, err_addr, freq_valid}, 32'd0);
        check_val({tag, "_frame_word"}, frame_word, 32'd0);
        check_val({tag, "_frame_addr"}, {29'd0, frame_addr}, 32'd0);
        check_val({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
        check_val({tag, "_r0"}, {4'd0, r0_int, r0_frac}, 32'd0);
        check_val({tag, "_freq_code"}, {9'd0, freq_code}, 32'd0);
    endtask

    // Drive n bits (bits[n-1] first) at the given sclk phase length, then latch.
    task automatic shift_frame(input logic [63:0] bits, input int n, input int ph);
        @(negedge clk);
        le = 1'b0;
        sclk = 1'b0;
        repeat (ph + 2) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            sdata = bits[i];
            sclk = 1'b0;
            repeat (ph) @(negedge clk);
            sclk = 1'b1;
            repeat (ph) @(negedge clk);
            if (i == n - 1) check_val("busy_shift", {31'd0, busy}, 32'd1);
        end
        sclk = 1'b0;
        repeat (ph) @(negedge clk);
        le = 1'b1;
    endtask

    task automatic run_frame(input logic [63:0] bits, input int n, input int ph);
        logic [31:0] word;
        logic [2:0]  addr;
        logic [31:0] old_val;
        int          kind;
        int          found;
        int          exp_int, exp_frac;
        word = bits[31:0];
        addr = word[2:0];
        kind = (n < 32) ? 1 : ((addr >= 3'd6) ? 2 : 0);
        rd_addr = (kind == 1) ? 3'($urandom_range(0, 7)) : addr;
        old_val = m_regs[rd_addr];
        exp_int  = int'(word[30:15]);
        exp_frac = int'(word[14:3]);

        // sclk activity while le is high must be ignored
        repeat (2) begin
            sclk = 1'b1; repeat (3) @(negedge clk);
            sclk = 1'b0; repeat (3) @(negedge clk);
        end

        shift_frame(bits, n, ph);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_valid || err_short || err_addr) begin
                found = 1;
                break;
            end
        end
        check_val("pulse_seen", found, 1);
        if (found == 1) begin
            check_val("frame_valid", {31'd0, frame_valid}, {31'd0, kind == 0});
            check_val("err_short", {31'd0, err_short}, {31'd0, kind == 1});
            check_val("err_addr", {31'd0, err_addr}, {31'd0, kind == 2});
            check_val("freq_valid_latch", {31'd0, freq_valid}, 32'd0);
            @(negedge clk);
            check_val("pulse_width", {29'd0, frame_valid, err_short, err_addr}, 32'd0);
            check_val("freq_valid_early", {31'd0, freq_valid}, 32'd0);
            check_val("rd_old", rd_data, old_val);
            if (kind == 0) begin
                m_regs[addr] = word;
                if (m_count < 65535) m_count++;
                check_val("frame_word", frame_word, word);
                check_val("frame_addr", {29'd0, frame_addr}, {29'd0, addr});
                if (addr == 3'd0) begin
                    check_val("r0_int", {16'd0, r0_int}, exp_int);
                    check_val("r0_frac", {20'd0, r0_frac}, exp_frac);
                end
            end
            check_val("frame_count", {16'd0, frame_count}, m_count);
            @(negedge clk);
            check_val("rd_new", rd_data, m_regs[rd_addr]);
            check_val("freq_valid", {31'd0, freq_valid}, {31'd0, kind == 0 && addr == 3'd0});
            if (kind == 0 && addr == 3'd0)
                check_val("freq_code", {9'd0, freq_code}, exp_int * 100 + exp_frac);
            check_val("busy_idle", {31'd0, busy}, 32'd0);
        end
        $display("frame %0d: bits=%0d ph=%0d word=0x%08h kind=%0d count=%0d checks=%0d failures=%0d",
                 frame_no, n, ph, word, kind, m_count, checks, failures);
        frame_no++;
    endtask

    initial begin
        logic [63:0] bits;
        int          n;
        int          seen;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(64'h0000_0000_0018_0005, 32, 4);
        run_frame(64'h0000_0000_0002_0128, 32, 3);
        check_val("r0_int_dir", {16'd0, r0_int}, 32'd4);
        check_val("r0_frac_dir", {20'd0, r0_frac}, 32'd37);
        check_val("freq_code_dir", {9'd0, freq_code}, 32'd437);
        run_frame(64'h0000_0001_0018_0005, 33, 3);
        run_frame(64'h0000_0000_000A_BCDE, 20, 3);
        run_frame(64'h0000_0000_0000_0007, 32, 3);

        // Reset in the middle of a frame, with the bus returned to idle during reset.
        @(negedge clk);
        le = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            sdata = 1'($urandom_range(0, 1));
            sclk = 1'b0; repeat (3) @(negedge clk);
            sclk = 1'b1; repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        le = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (frame_valid || err_short || err_addr || freq_valid) seen++;
        end
        check_val("no_pulse_after_rst", seen, 0);
        run_frame(64'h0000_0000_0018_0005, 32, 3);

        // R0..R5 back to back at the minimum sclk phase.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int a = 0; a < 6; a++) begin
            bits = {32'd0, $urandom() & 32'hFFFF_FFF8 | 32'(a)};
            run_frame(bits, 32, 3);
        end
        check_val("count_six", {16'd0, frame_count}, 32'd6);

        // Random frames: mostly valid, some long, some short, some bad addresses.
        for (int f = 0; f < 24; f++) begin
            bits = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(1, 31);
                1:       n = $urandom_range(33, 40);
                default: n = 32;
            endcase
            run_frame(bits, n, $urandom_range(3, 5));
        end

        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            rd_addr = 3'(a);
            @(negedge clk);
            check_val("readback", rd_data, m_regs[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
